// File: rtl/instr_controller.sv
`default_nettype none
// ============================================================================
//  Module   : instr_controller
//  Purpose  : Instruction register, decoder and multi-cycle control FSM that
//             drives the register-file, A/B/C load, mux, shifter and ALU
//             controls of the downstream datapath.
//  Ports    : clk, reset (async, active-high)
//             in[15:0] instruction word, load (capture into IR), s (start)
//             w (idle/ready), datapath_in[15:0] (sign-extended imm8)
//             write, vsel, loada, loadb, asel, bsel, loadc, loads
//             readnum[2:0], writenum[2:0], shift[1:0], ALUop[1:0]
//  Revision : 1.0  initial release
// ============================================================================
module instr_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [15:0] datapath_in,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WR_IMM = 3'd2;
  localparam logic [2:0] S_GET_A  = 3'd3;
  localparam logic [2:0] S_GET_B  = 3'd4;
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_WR_RD  = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_ir;

  // Instruction fields
  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];

  // Instruction class decode
  logic w_mov_imm;
  logic w_mov_reg;
  logic w_alu_ab;   // ADD, CMP, AND: need both operands
  logic w_mvn;
  logic w_cmp;

  assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_alu_ab  = (w_opcode == 3'b101) && (w_op != 2'b11);
  assign w_mvn     = (w_opcode == 3'b101) && (w_op == 2'b11);
  assign w_cmp     = (w_opcode == 3'b101) && (w_op == 2'b01);

  assign datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};

  // IR only captures while idle so the fields stay stable for a whole instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir <= 16'h0000;
    end else if (load && (r_state == S_WAIT)) begin
      r_ir <= in;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:   if (s) w_next = S_DECODE;
      S_DECODE: begin
        if (w_mov_imm)                w_next = S_WR_IMM;
        else if (w_alu_ab)            w_next = S_GET_A;
        else if (w_mov_reg || w_mvn)  w_next = S_GET_B;
        else                          w_next = S_WAIT;   // illegal: nothing written
      end
      S_WR_IMM: w_next = S_WAIT;
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_EXEC;
      S_EXEC:   w_next = w_cmp ? S_WAIT : S_WR_RD;
      S_WR_RD:  w_next = S_WAIT;
      default:  w_next = S_WAIT;
    endcase
  end

  // Moore outputs
  always_comb begin
    w        = 1'b0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (r_state)
      S_WAIT:   w = 1'b1;
      S_WR_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = w_rn;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = w_sh;
        // MOV reg passes B through the adder with A forced to zero.
        ALUop = w_mov_reg ? 2'b00 : w_op;
        asel  = w_mov_reg;
        loadc = 1'b1;
        loads = 1'b1;
      end
      S_WR_RD: begin
        write    = 1'b1;
        writenum = w_rd;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_controller
//  Purpose  : Directed self-checking bench for instr_controller, with a small
//             behavioural datapath so register results can be checked.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load, s;
  logic        w, write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [15:0] datapath_in;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  instr_controller dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .datapath_in(datapath_in), .write(write), .vsel(vsel), .loada(loada),
    .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .readnum(readnum), .writenum(writenum), .shift(shift), .ALUop(ALUop)
  );

  // Behavioural datapath
  logic [15:0] R [8];
  logic [15:0] A, B, C, sh_b, ain, bin, alu;
  logic        Z;

  always_comb begin
    sh_b = B;
    case (shift)
      2'b01: sh_b = {B[14:0], 1'b0};
      2'b10: sh_b = {1'b0, B[15:1]};
      2'b11: sh_b = {B[15], B[15:1]};
      default: sh_b = B;
    endcase
    ain = asel ? 16'h0 : A;
    bin = bsel ? datapath_in : sh_b;
    case (ALUop)
      2'b00: alu = ain + bin;
      2'b01: alu = ain - bin;
      2'b10: alu = ain & bin;
      default: alu = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) begin
      R[writenum] <= vsel ? datapath_in : C;
      wr_cnt <= wr_cnt + 1;
    end
    if (loada) A <= R[readnum];
    if (loadb) B <= R[readnum];
    if (loadc) C <= alu;
    if (loads) Z <= (alu == 16'h0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Load+start an instruction, count edges until w returns, check the EXEC
  // controls on edge exec_edge, and check the number of register writes.
  task automatic run_instr(input string tag, input logic [15:0] instr,
                           input int lat, input int exec_edge,
                           input logic exp_asel, input logic [1:0] exp_alu,
                           input logic [1:0] exp_sh, input int exp_wr,
                           input bit glitch);
    int n;
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    in = instr; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    n = 1;
    while (!w && n < 20) begin
      if (n == exec_edge) begin
        check({tag, " exec ctl"}, {loadc, loads, asel, bsel, ALUop, shift, write},
              {1'b1, 1'b1, exp_asel, 1'b0, exp_alu, exp_sh, 1'b0});
        if (glitch) begin
          in = 16'hD6FF; load = 1'b1;
        end
      end else begin
        load = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    load = 1'b0;
    check({tag, " latency"}, n, lat);
    check({tag, " writes"}, wr_cnt - w0, exp_wr);
  endtask

  initial begin
    reset = 1'b1; in = 16'h0; load = 1'b0; s = 1'b0;
    #12;
    check("reset w", {w, write, loadc, datapath_in}, {1'b1, 1'b0, 1'b0, 16'h0});
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in the middle of GET_B of ADD R2,R1,R0,LSL#1
    @(negedge clk);
    in = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk); #1; load = 1'b0; s = 1'b0;   // DECODE
    @(posedge clk);                               // GET_A
    @(posedge clk); #1;                           // GET_B
    check("get_b ctl", {w, loadb, readnum, datapath_in}, {1'b0, 1'b1, 3'd0, 16'h0048});
    #2 reset = 1'b1;
    #1;
    check("async rst", {w, write, loada, loadb, loadc, datapath_in},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    reset = 1'b0;

    // MOV R0,#7; MOV R1,#2; ADD R2,R1,R0,LSL#1
    run_instr("mov r0", 16'hD007, 3, 0, 1'b0, 2'b00, 2'b00, 1, 1'b0);
    run_instr("mov r1", 16'hD102, 3, 0, 1'b0, 2'b00, 2'b00, 1, 1'b0);
    run_instr("add r2", 16'hA148, 6, 4, 1'b0, 2'b00, 2'b01, 1, 1'b0);
    check("R2", R[2], 16'h0010);

    // MOV R0,#13; MOV R1,#7; CMP R0,R1,LSR#1
    run_instr("mov r0b", 16'hD00D, 3, 0, 1'b0, 2'b00, 2'b00, 1, 1'b0);
    run_instr("mov r1b", 16'hD107, 3, 0, 1'b0, 2'b00, 2'b00, 1, 1'b0);
    run_instr("cmp", 16'hA811, 5, 4, 1'b0, 2'b01, 2'b10, 0, 1'b0);
    check("cmp regs", {R[0], R[1]}, {16'd13, 16'd7});
    check("cmp Z", Z, 1'b0);

    // MOV R3,#-1
    run_instr("mov r3", 16'hD3FF, 3, 0, 1'b0, 2'b00, 2'b00, 1, 1'b0);
    check("imm sext", datapath_in, 16'hFFFF);
    check("R3", R[3], 16'hFFFF);

    // MOV R4,R3,LSR#1 then MVN R5,R4
    run_instr("mov r4", 16'hC093, 5, 3, 1'b1, 2'b00, 2'b10, 1, 1'b0);
    check("R4", R[4], 16'h7FFF);
    run_instr("mvn r5", 16'hB8A4, 5, 3, 1'b0, 2'b11, 2'b00, 1, 1'b0);
    check("R5", R[5], 16'h8000);

    // Illegal opcode
    run_instr("illegal", 16'hE000, 2, 0, 1'b0, 2'b00, 2'b00, 0, 1'b0);

    // ADD R6,R1,R0 with a load pulse during EXEC that must be ignored
    run_instr("add r6", 16'hA1C0, 6, 4, 1'b0, 2'b00, 2'b00, 1, 1'b1);
    check("R6", R[6], 16'd20);
    check("ir held", datapath_in, 16'hFFC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
